div_clk_monitor: RTL

- Monitors the divided clock produced by the clock divider.
- Runs on the same source clock as the divider and samples the divided output as data.
- Measures each half-period in source-clock cycles and checks it against the programmed divide factor.
- Reports lock, sticky faults and per-edge measurements to the control/status logic.

---
 rtl/div_clk_monitor.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: measures each half-period of clk_div in clk_ip cycles and checks lock/faults.
// Optional running min/max history outputs are enabled with `define DIV_CLK_MONITOR_HIST_EN.
module div_clk_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 0
) (
    input  logic             clk_ip,
    input  logic             rst,
    input  logic             clk_div,
    input  logic [3:0]       factor,
    input  logic             clr_fault,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code
`ifdef DIV_CLK_MONITOR_HIST_EN
    ,
    output logic [CNT_W-1:0] hp_min,
    output logic [CNT_W-1:0] hp_max
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISMATCH = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_HALTED   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED,
        FAULT
    } state_e;

    state_e           state_q, state_d;
    logic             d1_q;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [3:0]       factor_q;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0] half_period_q, half_period_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, fault_q;
    logic [1:0]       fault_code_q, fault_code_d;

    logic             div_edge;
    logic             factor_chg;
    logic [CNT_W:0]   meas_ext, fac_ext, diff;
    logic             meas_good;
    logic [3:0]       good_inc;
    logic             timeout;

    assign div_edge   = (clk_div != d1_q);
    assign factor_chg = (factor != factor_q);

    // The old run_cnt is the measurement; compare one bit wider so the difference cannot wrap.
    assign meas_ext  = {1'b0, run_cnt_q};
    assign fac_ext   = (CNT_W+1)'(factor);
    assign diff      = (meas_ext >= fac_ext) ? (meas_ext - fac_ext) : (fac_ext - meas_ext);
    assign meas_good = (diff <= TOL_W);
    assign good_inc  = good_cnt_q + 4'd1;
    assign timeout   = (run_cnt_q == CNT_MAX) && (factor != 4'd0);

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (div_edge) begin
            run_cnt_d = CNT_W'(1);
        end else if (run_cnt_q != CNT_MAX) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        fault_code_d  = fault_code_q;
        half_period_d = half_period_q;
        meas_valid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (factor_chg) begin
                    good_cnt_d = 4'd0;
                end else if (div_edge) begin
                    // First interval after (re)start is partial and is thrown away.
                    good_cnt_d = 4'd0;
                    if (factor == 4'd0) begin
                        state_d      = FAULT;
                        fault_code_d = FC_HALTED;
                    end else begin
                        state_d = MEASURE;
                    end
                end
            end

            MEASURE, LOCKED: begin
                if (factor_chg) begin
                    state_d    = IDLE;
                    good_cnt_d = 4'd0;
                end else if (div_edge) begin
                    meas_valid_d  = 1'b1;
                    half_period_d = run_cnt_q;
                    if (factor == 4'd0) begin
                        state_d      = FAULT;
                        fault_code_d = FC_HALTED;
                    end else if (!meas_good) begin
                        state_d      = FAULT;
                        fault_code_d = FC_MISMATCH;
                    end else if (state_q == MEASURE) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (timeout) begin
                    state_d      = FAULT;
                    fault_code_d = FC_TIMEOUT;
                end
            end

            FAULT: begin
                if (clr_fault) begin
                    state_d      = IDLE;
                    fault_code_d = FC_NONE;
                    good_cnt_d   = 4'd0;
                end else if (div_edge) begin
                    meas_valid_d  = 1'b1;
                    half_period_d = run_cnt_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ip) begin
        if (rst) begin
            state_q       <= IDLE;
            d1_q          <= 1'b0;
            run_cnt_q     <= '0;
            factor_q      <= factor;
            good_cnt_q    <= 4'd0;
            half_period_q <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
        end else begin
            state_q       <= state_d;
            d1_q          <= clk_div;
            run_cnt_q     <= run_cnt_d;
            factor_q      <= factor;
            good_cnt_q    <= good_cnt_d;
            half_period_q <= half_period_d;
            meas_valid_q  <= meas_valid_d;
            locked_q      <= (state_d == LOCKED);
            fault_q       <= (state_d == FAULT);
            fault_code_q  <= fault_code_d;
        end
    end

    assign half_period = half_period_q;
    assign meas_valid  = meas_valid_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

`ifdef DIV_CLK_MONITOR_HIST_EN
    logic [CNT_W-1:0] hp_min_q, hp_max_q;
    logic             hist_clr;

    // Same restart conditions that send the FSM back to IDLE.
    assign hist_clr = (state_q == FAULT) ? clr_fault : factor_chg;

    always_ff @(posedge clk_ip) begin
        if (rst || hist_clr) begin
            hp_min_q <= '1;
            hp_max_q <= '0;
        end else if (meas_valid_d) begin
            if (run_cnt_q < hp_min_q) hp_min_q <= run_cnt_q;
            if (run_cnt_q > hp_max_q) hp_max_q <= run_cnt_q;
        end
    end

    assign hp_min = hp_min_q;
    assign hp_max = hp_max_q;
`endif

endmodule
